// File: rtl/slow_timer_pkg.sv
// Shared constants and types for the slow timer scheduler.
package slow_timer_pkg;

  localparam int TIME_W     = 11;
  localparam int NUM_CH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slow_timer_channel.sv
// One requester channel: loads a tick count, counts shared ticks down and
// emits a single-cycle expiry pulse.
//
// state | meaning
// IDLE  | not counting, busy=0
// RUN   | ticks outstanding in remaining, busy=1
module slow_timer_channel
  import slow_timer_pkg::*;
(
  input  logic              clk,
  input  logic              resetN,
  input  logic              tick,
  input  logic              request,
  input  logic [TIME_W-1:0] load_time,
  output logic              slowClk,
  output logic              busy
);

  ch_state_t         state;
  logic [TIME_W-1:0] remaining;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      remaining <= '0;
      slowClk   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      slowClk <= 1'b0;
      // A request always wins over a tick on the same edge, including the
      // terminal one, so a reload swallows the pending expiry.
      if (request) begin
        if (load_time != '0) begin
          state     <= RUN;
          remaining <= load_time;
          busy      <= 1'b1;
        end else begin
          state     <= IDLE;
          remaining <= '0;
          busy      <= 1'b0;
          slowClk   <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          RUN: begin
            if (tick) begin
              remaining <= remaining - TIME_W'(1);
              if (remaining == TIME_W'(1)) begin
                state   <= IDLE;
                busy    <= 1'b0;
                slowClk <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/slow_timer_scheduler.sv
// Shared slow-tick prescaler feeding NUM_CH independent countdown channels.
// Build option SLOWCLK_PAUSE_EN: pause freezes the prescaler and masks tick.
module slow_timer_scheduler
  import slow_timer_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int TICK_DIV = 2_500_000
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     pause,
  input  logic [NUM_CH-1:0]        requestSlowClk,
  input  logic [NUM_CH*TIME_W-1:0] slowClkTime,
  output logic [NUM_CH-1:0]        slowClk,
  output logic [NUM_CH-1:0]        busy,
  output logic                     tick
);

  localparam int            PW        = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          at_max;
  logic          hold;

  assign at_max = (presc == PRESC_MAX);

`ifdef SLOWCLK_PAUSE_EN
  assign hold = pause;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign hold         = 1'b0;
`endif

  assign tick = at_max & ~hold & resetN;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      presc <= '0;
    end else if (!hold) begin
      presc <= at_max ? '0 : presc + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    slow_timer_channel u_ch (
      .clk       (clk),
      .resetN    (resetN),
      .tick      (tick),
      .request   (requestSlowClk[i]),
      .load_time (slowClkTime[i*TIME_W +: TIME_W]),
      .slowClk   (slowClk[i]),
      .busy      (busy[i])
    );
  end

endmodule

// File: tb/tb_slow_timer_scheduler.sv
// Directed bench for slow_timer_scheduler with TICK_DIV=4; expiry pulses are
// scoreboarded against hand-computed cycle numbers.
module tb_slow_timer_scheduler;
  import slow_timer_pkg::*;

  localparam int NCH  = 4;
  localparam int TDIV = 4;

  logic                  clk    = 1'b0;
  logic                  resetN = 1'b0;
  logic                  pause  = 1'b0;
  logic [NCH-1:0]        requestSlowClk = '0;
  logic [NCH*TIME_W-1:0] slowClkTime    = '0;
  logic [NCH-1:0]        slowClk;
  logic [NCH-1:0]        busy;
  logic                  tick;

  // cyc = number of posedges so far; negedge k sees cyc == k.
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;
  exp_t sb[$];

  slow_timer_scheduler #(.NUM_CH(NCH), .TICK_DIV(TDIV)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .pause          (pause),
    .requestSlowClk (requestSlowClk),
    .slowClkTime    (slowClkTime),
    .slowClk        (slowClk),
    .busy           (busy),
    .tick           (tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic req(input int ch, input int tm, input int exp_cyc);
    requestSlowClk[ch] = 1'b1;
    slowClkTime[ch*TIME_W +: TIME_W] = TIME_W'(tm);
    if (exp_cyc > 0) sb.push_back(exp_t'{ch, exp_cyc});
  endtask

  // Monitor: every observed expiry pulse must match a pending expectation.
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (slowClk[i] === 1'b1) begin : pulse_seen
        int hit;
        hit = -1;
        foreach (sb[j]) if (sb[j].ch == i && sb[j].cyc == cyc) hit = j;
        checks++;
        if (hit < 0) begin
          errors++;
          $display("FAIL pulse_ch%0d at cycle %0d: got slowClk=1, expected 0 (no expiry due)", i, cyc);
        end else begin
          sb.delete(hit);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected finish by cycle 175", cyc);
    $fatal(1);
  end

  initial begin
    // Reset state
    wait_cyc(2);
    check("reset_busy", int'(busy), 0);
    check("reset_slowClk", int'(slowClk), 0);
    check("reset_tick", int'(tick), 0);
    wait_cyc(4);
    resetN = 1'b1;
    // Release at negedge 4: tick visible at cyc 7, tick edges at multiples of 4
    wait_cyc(6);
    check("tick_low", int'(tick), 0);
    wait_cyc(7);
    check("tick_first", int'(tick), 1);
    wait_cyc(8);
    check("tick_single_cycle", int'(tick), 0);

    // ch0 time 5, load on tick edge 12 (not counted): ticks 16..32 -> pulse 32
    wait_cyc(11);
    req(0, 5, 32);
    wait_cyc(12);
    requestSlowClk = '0;
    check("t1_busy_set", int'(busy[0]), 1);
    wait_cyc(31);
    check("t1_busy_hold", int'(busy[0]), 1);
    wait_cyc(32);
    check("t1_busy_clear", int'(busy[0]), 0);

    // ch1 time 0: pulse on the next cycle only, never busy
    wait_cyc(34);
    req(1, 0, 35);
    wait_cyc(35);
    requestSlowClk = '0;
    check("t2_busy", int'(busy[1]), 0);
    wait_cyc(36);
    check("t2_busy_after", int'(busy[1]), 0);

    // ch2 time 3 loaded at 38: terminal tick edge 48 meets a reload -> pulse 60
    wait_cyc(37);
    req(2, 3, 60);
    wait_cyc(38);
    requestSlowClk = '0;
    wait_cyc(47);
    check("t3_busy_pre", int'(busy[2]), 1);
    req(2, 3, 0);
    wait_cyc(48);
    requestSlowClk = '0;
    check("t3_busy_reload", int'(busy[2]), 1);
    wait_cyc(59);
    check("t3_busy_hold", int'(busy[2]), 1);
    wait_cyc(60);
    check("t3_busy_clear", int'(busy[2]), 0);

    // All channels at once, times 1..4 loaded at 64 -> pulses 68,72,76,80
    wait_cyc(63);
    for (int i = 0; i < NCH; i++) req(i, i + 1, 68 + 4 * i);
    wait_cyc(64);
    requestSlowClk = '0;
    check("t4_busy_all", int'(busy), 15);
    wait_cyc(72);
    check("t4_busy_mid", int'(busy), 12);
    wait_cyc(80);
    check("t4_busy_none", int'(busy), 0);

    // ch0 time 2 loaded at 84; pause over edges 88..127
`ifdef SLOWCLK_PAUSE_EN
    wait_cyc(83);
    req(0, 2, 132);
`else
    wait_cyc(83);
    req(0, 2, 92);
`endif
    wait_cyc(84);
    requestSlowClk = '0;
    wait_cyc(87);
    pause = 1'b1;
    #1;
`ifdef SLOWCLK_PAUSE_EN
    check("t5_tick_masked", int'(tick), 0);
    wait_cyc(100);
    check("t5_busy_paused", int'(busy[0]), 1);
`else
    check("t5_tick_ignores_pause", int'(tick), 1);
    wait_cyc(100);
    check("t5_busy_done", int'(busy[0]), 0);
`endif
    wait_cyc(126);
    check("t5_tick_126", int'(tick), 0);
    wait_cyc(127);
    pause = 1'b0;
    #1;
    check("t5_tick_127", int'(tick), 1);

    // ch3 time 6 loaded at 136, reset after ticks 140,144
    wait_cyc(135);
    req(3, 6, 0);
    wait_cyc(136);
    requestSlowClk = '0;
    check("t6_busy_set", int'(busy[3]), 1);
    wait_cyc(144);
    check("t6_busy_before_reset", int'(busy[3]), 1);
    wait_cyc(145);
    resetN = 1'b0;
    #1;
    check("t6_busy_reset", int'(busy), 0);
    check("t6_slowClk_reset", int'(slowClk), 0);
    wait_cyc(147);
    check("t6_tick_reset", int'(tick), 0);
    wait_cyc(150);
    resetN = 1'b1;
    // Prescaler restarts at 0: tick visible at 153, tick edges 154+4k
    wait_cyc(152);
    check("t6_tick_post_low", int'(tick), 0);
    wait_cyc(153);
    check("t6_tick_post_first", int'(tick), 1);
    wait_cyc(160);
    check("t6_busy_abandoned", int'(busy), 0);
    // New request after reset: load on tick edge 166 -> pulse 170
    wait_cyc(165);
    req(3, 1, 170);
    wait_cyc(166);
    requestSlowClk = '0;
    check("t6_busy_restart", int'(busy[3]), 1);
    wait_cyc(175);
    check("pending_pulses", sb.size(), 0);
    foreach (sb[j]) $display("  missing pulse: ch%0d due at cycle %0d", sb[j].ch, sb[j].cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slow_timer_scheduler.md
SLOW_TIMER_SCHEDULER -- requirements
Module: slow_timer_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of requester channels.
REQ-002 The block SHALL have parameter TICK_DIV, default 2_500_000: clk cycles per slow tick.
REQ-003 The block SHALL have port clk, input, 1: system clock; all logic on posedge.
REQ-004 The block SHALL have port resetN, input, 1: reset, asynchronous, active-low.
REQ-005 The block SHALL have port pause, input, 1: freezes the time base.
REQ-006 The block SHALL have port requestSlowClk, input, NUM_CH: one-cycle load request per channel.
REQ-007 The block SHALL have port slowClkTime, input, NUM_CH x 11: tick count per channel, sampled with its request.
REQ-008 The block SHALL have port slowClk, output, NUM_CH: one-cycle expiry pulse per channel.
REQ-009 The block SHALL have port busy, output, NUM_CH: channel counting.
REQ-010 The block SHALL have port tick, output, 1: shared time-base strobe, for observation.

Function
REQ-011 The prescaler SHALL count 0..TICK_DIV-1, assert tick for exactly one clk when at TICK_DIV-1, and then wrap to 0.
REQ-012 Each channel SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-013 On a clk edge with requestSlowClk[i]=1 and slowClkTime[i]>0, channel i SHALL load remaining=slowClkTime[i] and enter RUN, from any state (restart when already in RUN).
REQ-014 On an edge with requestSlowClk[i]=1 and slowClkTime[i]=0, channel i SHALL stay IDLE and drive slowClk[i]=1 in the following cycle only.
REQ-015 In RUN, on an edge with tick=1, remaining SHALL decrement by 1 (11-bit, unsigned).
REQ-016 When a decrement reaches 0, the channel SHALL go IDLE and drive slowClk[i]=1 for exactly the next cycle.
REQ-017 Latency SHALL be exactly N tick strobes after load for slowClkTime=N>0; a tick coincident with the load edge SHALL NOT count.
REQ-018 When requestSlowClk[i] coincides with a terminal decrement, the request SHALL win: reload occurs and no slowClk[i] pulse is emitted.
REQ-019 Channels SHALL be independent; simultaneous requests on all channels SHALL all be accepted in the same cycle.
REQ-020 slowClk and busy SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-021 While resetN=0, prescaler, remaining and tick SHALL be 0, all channels IDLE, and slowClk=0 and busy=0.
REQ-022 Reset asserted mid-count SHALL abandon all timers with no expiry pulse; after release, counting SHALL resume only on new requests.

Configuration
REQ-023 With macro SLOWCLK_PAUSE_EN defined, pause=1 SHALL hold the prescaler value and suppress tick; requests and time-0 pulses SHALL still be serviced.
REQ-024 Without SLOWCLK_PAUSE_EN, the pause port SHALL remain present but be ignored.

Structure
REQ-025 Package slow_timer_pkg SHALL hold TIME_W=11, the channel state enum (IDLE, RUN) and the default NUM_CH.
REQ-026 Per-channel logic SHALL be one sub-module, slow_timer_channel, instantiated NUM_CH times.
REQ-027 The prescaler SHALL be shared, living in the top level.

Verification (TICK_DIV=4)
REQ-028 Bench SHALL apply reset, then request ch0 with time 5 -> busy[0]=1 next cycle; slowClk[0] pulses one cycle after the 5th tick (about 20 clk); busy[0]=0.
REQ-029 Bench SHALL request ch1 with time 0 -> slowClk[1]=1 on the next cycle only; busy[1] never 1.
REQ-030 Bench SHALL request ch2 with time 3, then re-request ch2 with time 3 on the cycle of its terminal tick -> no pulse; pulse after 3 further ticks.
REQ-031 Bench SHALL request all 4 channels with times 1,2,3,4 in one cycle -> pulses on successive ticks in channel order.
REQ-032 With SLOWCLK_PAUSE_EN, bench SHALL request ch0 with time 2 and hold pause for 40 clk mid-count -> no tick during pause; expiry delayed by exactly 40 clk.
REQ-033 Bench SHALL request ch3 with time 6 and assert resetN=0 after 2 ticks -> busy=0, no slowClk pulse, and prescaler=0 after release.
